// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, supported oversampling ratios and parity selectors.
// Imported by both the TX frame generator and the RX sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle timer: counts 0..prescale_latched-1 while enabled and pulses bit_done
// on the terminal count, then wraps to zero.
module uart_tx_bit_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [5:0] prescale_latched,
  output logic       bit_done
);

  logic [5:0] cnt_r;
  logic       terminal_s;

  assign terminal_s = (cnt_r == (prescale_latched - 6'd1));
  assign bit_done   = enable & terminal_s;

  // cycle counter, held at zero whenever no frame is in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= 6'd0;
    end else if (!enable || terminal_s) begin
      cnt_r <= 6'd0;
    end else begin
      cnt_r <= cnt_r + 6'd1;
    end
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: serialises a byte as start, LSB-first data, optional parity and one
// stop bit, holding each bit for the prescale ratio latched when the frame was accepted.
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [5:0]            prescale,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  uart_state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0]      bit_idx_r, bit_idx_nxt_s, idx_inc_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [5:0]            prescale_r;
  logic                  par_en_r, par_bit_r;
  logic                  tx_r, tx_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  accept_s, bit_done_s, timer_en_s;

  assign timer_en_s = (state_r != IDLE);
  assign idx_inc_s  = bit_idx_r + IDX_W'(1);
  assign TX_OUT     = tx_r;
  assign busy       = busy_r;

  uart_tx_bit_timer u_bit_timer (
    .CLK              (CLK),
    .RST              (RST),
    .enable           (timer_en_s),
    .prescale_latched (prescale_r),
    .bit_done         (bit_done_s)
  );

  // next-state, bit index and registered-output precomputation
  always_comb begin
    state_nxt_s   = state_r;
    bit_idx_nxt_s = bit_idx_r;
    tx_nxt_s      = tx_r;
    busy_nxt_s    = busy_r;
    accept_s      = 1'b0;
    case (state_r)
      IDLE: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;
        if (Data_Valid && (prescale != 6'd0)) begin
          accept_s      = 1'b1;
          state_nxt_s   = START;
          bit_idx_nxt_s = '0;
          tx_nxt_s      = 1'b0;
          busy_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_nxt_s   = DATA;
          bit_idx_nxt_s = '0;
          tx_nxt_s      = data_r[0];
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_idx_r == LAST_IDX) begin
            if (par_en_r) begin
              state_nxt_s = PARITY;
              tx_nxt_s    = par_bit_r;
            end else begin
              state_nxt_s = STOP;
              tx_nxt_s    = 1'b1;
            end
          end else begin
            bit_idx_nxt_s = idx_inc_s;
            tx_nxt_s      = data_r[idx_inc_s];
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          state_nxt_s = STOP;
          tx_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_nxt_s = IDLE;
          tx_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // state, index and line registers; reset drops any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      bit_idx_r <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // shadow copy of the request so live inputs cannot disturb the frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_r     <= '0;
      prescale_r <= 6'd0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
    end else if (accept_s) begin
      data_r     <= P_DATA;
      prescale_r <= prescale;
      par_en_r   <= PAR_EN;
      par_bit_r  <= calc_parity(P_DATA, PAR_TYP);
    end else begin
      data_r     <= data_r;
      prescale_r <= prescale_r;
      par_en_r   <= par_en_r;
      par_bit_r  <= par_bit_r;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed self-checking bench for uart_tx_frame_gen: frame shape, parity, busy rejection,
// back-to-back framing, mid-frame reset and a mid-bit sampling receive model.
module tb_uart_tx_frame_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_gen #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .prescale   (prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  // expected line level k cycles after the first start-bit cycle
  function automatic logic exp_line(input logic [7:0] d, input int ps, input bit pen,
                                    input logic pbit, input int k);
    int b;
    b = k / ps;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else if (pen && b == 9) return pbit;
    else return 1'b1;
  endfunction

  // one-cycle request; returns at the first sample after the accepting edge
  task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pen, input logic ptyp);
    @(negedge CLK);
    P_DATA = d; prescale = ps; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // walks a frame while busy, counting cycles whose line level differs from the expected pattern
  task automatic run_frame(input logic [7:0] d, input int ps, input bit pen, input logic pbit,
                           output int bad, output int blen);
    bad = 0; blen = 0;
    for (int k = 0; k < 2000; k++) begin
      if (busy !== 1'b1) break;
      if (TX_OUT !== exp_line(d, ps, pen, pbit, k)) bad++;
      blen++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    Data_Valid = 1'b1; P_DATA = 8'h00; prescale = 6'd8;
    repeat (2) @(negedge CLK);
    tests_run++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
    RST = 1'b0; Data_Valid = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_prescale_zero;
    int seen;
    seen = 0;
    send(8'hFF, 6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b0 || TX_OUT !== 1'b1) seen++;
      @(negedge CLK);
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL prescale_zero: %0d non-idle cycles, expected 0", seen);
    end
  endtask

  task automatic test_basic_frame;
    int bad, blen;
    send(8'hA5, 6'd8, 1'b0, 1'b0);
    run_frame(8'hA5, 8, 1'b0, 1'b0, bad, blen);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL basic_waveform: %0d wrong cycles, expected 0", bad);
    end
    tests_run++;
    if (blen !== 80) begin
      tests_failed++;
      $display("FAIL basic_busy_len: got %0d cycles, expected 80", blen);
    end
    tests_run++;
    if (TX_OUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_idle_after: TX_OUT=%b, expected 1", TX_OUT);
    end
  endtask

  task automatic test_parity;
    int bad, blen;
    send(8'h07, 6'd16, 1'b1, 1'b0);
    run_frame(8'h07, 16, 1'b1, 1'b1, bad, blen);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL even_parity_waveform: %0d wrong cycles, expected 0", bad);
    end
    tests_run++;
    if (blen !== 176) begin
      tests_failed++;
      $display("FAIL even_parity_len: got %0d cycles, expected 176", blen);
    end
    send(8'h07, 6'd16, 1'b1, 1'b1);
    run_frame(8'h07, 16, 1'b1, 1'b0, bad, blen);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL odd_parity_waveform: %0d wrong cycles, expected 0", bad);
    end
    tests_run++;
    if (blen !== 176) begin
      tests_failed++;
      $display("FAIL odd_parity_len: got %0d cycles, expected 176", blen);
    end
  endtask

  task automatic test_busy_reject;
    int bad, blen, extra;
    bad = 0; blen = 0; extra = 0;
    send(8'h3C, 6'd32, 1'b0, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      if (busy !== 1'b1) break;
      if (TX_OUT !== exp_line(8'h3C, 32, 1'b0, 1'b0, k)) bad++;
      blen++;
      if (k == 100) begin
        P_DATA = 8'hFF; prescale = 6'd8; PAR_EN = 1'b1; Data_Valid = 1'b1;
      end else if (k == 319) begin
        Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
      @(negedge CLK);
    end
    Data_Valid = 1'b0; PAR_EN = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy !== 1'b0 || TX_OUT !== 1'b1) extra++;
      @(negedge CLK);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL busy_reject_waveform: %0d wrong cycles, expected 0", bad);
    end
    tests_run++;
    if (blen !== 320) begin
      tests_failed++;
      $display("FAIL busy_reject_len: got %0d cycles, expected 320", blen);
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL busy_reject_no_second: %0d non-idle cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int bad, p, waited;
    logic etx, ebusy;
    bad = 0;
    @(negedge CLK);
    P_DATA = 8'h55; prescale = 6'd8; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 3 * 81; k++) begin
      p = k % 81;
      etx   = (p < 80) ? exp_line(8'h55, 8, 1'b0, 1'b0, p) : 1'b1;
      ebusy = (p < 80);
      if (TX_OUT !== etx || busy !== ebusy) bad++;
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL back_to_back: %0d wrong cycles over 3 periods of 81, expected 0", bad);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_drain: busy=%b after %0d cycles, expected 0", busy, waited);
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad, blen, extra;
    extra = 0;
    send(8'hC3, 6'd8, 1'b0, 1'b0);
    repeat (34) @(negedge CLK);
    tests_run++;
    if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_frame_bit3: TX_OUT=%b busy=%b, expected TX_OUT=0 busy=1", TX_OUT, busy);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    tests_run++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_frame_reset: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b0 || TX_OUT !== 1'b1) extra++;
      @(negedge CLK);
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL mid_frame_dropped: %0d non-idle cycles, expected 0", extra);
    end
    send(8'h81, 6'd8, 1'b0, 1'b0);
    run_frame(8'h81, 8, 1'b0, 1'b0, bad, blen);
    tests_run++;
    if (bad !== 0 || blen !== 80) begin
      tests_failed++;
      $display("FAIL after_reset_frame: %0d wrong cycles, busy %0d cycles, expected 0 and 80", bad, blen);
    end
  endtask

  // receive model: samples the line at the middle of each bit period
  task automatic loopback_one(input logic [7:0] d, input logic [5:0] ps, input logic pen,
                              input logic ptyp);
    logic [7:0] rx;
    logic rx_start, rx_par, rx_stop, par_ok;
    int nb, mid, bi, waited;
    rx = 8'h00; rx_start = 1'b1; rx_par = 1'b0; rx_stop = 1'b0;
    nb  = 10 + int'(pen);
    mid = int'(ps) / 2;
    send(d, ps, pen, ptyp);
    for (int k = 0; k < nb * int'(ps); k++) begin
      if ((k % int'(ps)) == mid) begin
        bi = k / int'(ps);
        if (bi == 0) rx_start = TX_OUT;
        else if (bi <= 8) rx[bi-1] = TX_OUT;
        else if (pen && bi == 9) rx_par = TX_OUT;
        else rx_stop = TX_OUT;
      end
      @(negedge CLK);
    end
    par_ok = pen ? ((^{rx, rx_par}) == ptyp) : 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    tests_run++;
    if (rx !== d || rx_start !== 1'b0 || rx_stop !== 1'b1 || par_ok !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL loopback_ps%0d: rx=%h start=%b stop=%b par_ok=%b busy=%b, expected rx=%h start=0 stop=1 par_ok=1 busy=0",
               ps, rx, rx_start, rx_stop, par_ok, busy, d);
    end
  endtask

  task automatic test_loopback;
    logic [5:0] ps_tab [3];
    ps_tab[0] = 6'd8; ps_tab[1] = 6'd16; ps_tab[2] = 6'd32;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        loopback_one(8'($urandom_range(255, 0)), ps_tab[i],
                     1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescale_zero();
    test_basic_frame();
    test_parity();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
UART transmitter, the TX counterpart of the oversampled UART receive path. It accepts one parallel byte with a single-cycle valid and serialises it onto TX_OUT as: start bit, data bits LSB-first, optional parity bit, one stop bit. It runs on the same oversampled clock as the receiver, holding each bit for `prescale` clock cycles so the RX sampler, at the same prescale, sees mid-bit samples.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  input  1  oversampled clock, the same clock domain as the RX sampler.
RST  input  1  synchronous, active-high reset.
prescale  input  6  oversampling ratio, giving the clock cycles per bit. Supported values are 8, 16 and 32.
P_DATA  input  DATA_WIDTH  parallel byte to transmit.
Data_Valid  input  1  single-cycle request to transmit P_DATA.
PAR_EN  input  1  1 means a parity bit is inserted.
PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
TX_OUT  output  1  serial line, idle high.
busy  output  1  high while a frame is in flight.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - RST asserted at any time, including mid-frame, gives on the next CLK edge: state IDLE, TX_OUT=1, busy=0, bit counter=0, cycle counter=0.
  - The aborted frame is dropped, not resumed.
- Outputs are registered. There is no combinational path from any input to TX_OUT or busy.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If Data_Valid=1 and prescale!=0, the block accepts on that edge. It latches P_DATA, PAR_EN, PAR_TYP and prescale into shadow registers and computes parity.
  - On accept, the next state is START.
  - If prescale=0, the request is ignored and the state stays IDLE.
- Latency: with acceptance at edge N, TX_OUT=0 and busy=1 from N+1.
- START: TX_OUT=0 for prescale cycles, then DATA.
- DATA:
  - TX_OUT = shadow_data[bit_idx], with bit_idx running 0..DATA_WIDTH-1, each bit held for prescale cycles.
  - After the last bit: if PAR_EN is latched high, go to PARITY; otherwise go to STOP.
- PARITY: TX_OUT = parity bit, held for prescale cycles, then STOP.
  - Even parity (PAR_TYP=0): parity = XOR-reduce of the data.
  - Odd parity (PAR_TYP=1): parity = XNOR-reduce of the data.
  - The total number of ones in data plus parity is even for even parity and odd for odd parity.
- STOP: TX_OUT=1 for prescale cycles, then IDLE.
  - busy drops to 0 on the same edge that enters IDLE.
- Frame duration, from the first start-bit cycle to the last stop-bit cycle, is (2 + DATA_WIDTH + PAR_EN) × prescale cycles.
- Cycle counter:
  - Width 6, counts 0..prescale_latched-1.
  - The terminal count (cnt == prescale_latched-1) advances the state or bit index and wraps the counter to 0.
  - The counter never uses the live prescale port mid-frame.
- Data_Valid while busy=1, including the final stop cycle, is ignored. There is no queueing.
- Back-to-back frames: at least one IDLE cycle with TX_OUT=1 separates them. A Data_Valid presented in that IDLE cycle is accepted.
- Changing P_DATA, PAR_EN, PAR_TYP or prescale mid-frame has no effect on the frame in flight.
- Non-8/16/32 nonzero prescale values are still honoured as cycles-per-bit. Only 8, 16 and 32 are guaranteed to interoperate with the RX sampler.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - PRESCALE_8 = 6'd8, PRESCALE_16 = 6'd16, PRESCALE_32 = 6'd32;
  - PAR_EVEN = 1'b0, PAR_ODD = 1'b1.
  - The RX side imports the same package.
- One sub-module, uart_tx_bit_timer, contains:
  - inputs CLK, RST, enable, prescale_latched;
  - output bit_done, a single-cycle pulse at terminal count;
  - the 6-bit cycle counter.
- The FSM, shift/index logic and parity register stay in uart_tx_frame_gen.

Test Plan:
1. Basic frame: RST, then prescale=8, PAR_EN=0, Data_Valid pulse with P_DATA=8'hA5.
   -> TX_OUT is 0 for 8 cycles, then 1,0,1,0,0,1,0,1 (LSB-first) at 8 cycles each, then 1 for 8 cycles.
   -> busy is high for exactly 80 cycles, then drops.
2. Even parity: prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=8'h07.
   -> Parity bit = 1. The frame lasts 176 cycles.
   -> The same run with PAR_TYP=1 gives parity bit = 0.
3. Busy rejection and input stability: prescale=32, P_DATA=8'h3C, pulse Data_Valid again 100 cycles later with P_DATA=8'hFF, and change prescale to 8 mid-frame.
   -> The serial stream decodes as 8'h3C at 32 cycles/bit. No second frame is sent.
4. Back-to-back: hold Data_Valid=1 continuously with P_DATA=8'h55, prescale=8, PAR_EN=0.
   -> Frames repeat with exactly one idle-high cycle between the stop bit and the next start bit, giving an 81-cycle period.
5. Reset mid-frame: assert RST for 1 cycle during data bit 3.
   -> The next edge gives TX_OUT=1 and busy=0.
   -> A subsequent Data_Valid with 8'h81 produces a clean full frame.
6. Loopback: connect TX_OUT to the UART RX path at prescale 8, 16 and 32, with random bytes and parity settings.
   -> The received byte equals the sent byte, and the RX parity check passes in all 3 prescale modes.
